// File: rtl/program_counter_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_pkg
// Purpose : Shared definitions for the program counter block: the control FSM
//           state enum, the next-PC source select used between the FSM and the
//           pc_next datapath, and the PC reset value.
// Ports   : none (package).
// Config  : PC_LINK_EN (see program_counter.sv) selects whether SEL_LINK can
//           ever be requested; the encoding is always present.
// -----------------------------------------------------------------------------
package program_counter_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  // Source of the next PC value, chosen by the FSM, built by pc_next.
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,  // keep current pc
    SEL_ZERO = 3'd1,  // restart from PC_RESET
    SEL_INC  = 3'd2,  // pc + 1
    SEL_ABS  = 3'd3,  // target as absolute address
    SEL_REL  = 3'd4,  // pc + signed target
    SEL_LINK = 3'd5   // return through the link register
  } pc_sel_t;

  // Address execution starts from after reset or a (re)start.
  localparam int unsigned PC_RESET = 32'd0;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Purpose : Purely combinational next-PC adder/mux for program_counter.
// Ports   :
//   sel     in  pc_sel_t : which next-PC source to produce
//   pc      in  D        : current program counter
//   target  in  D        : jump address or two's complement offset
//   link    in  D        : saved return address (zero when unused)
//   pc_nxt  out D        : selected next program counter
//   pc_inc  out D        : pc + 1 (mod 2^D), also used as the call return
// -----------------------------------------------------------------------------
module pc_next
  import program_counter_pkg::*;
#(
  parameter int D = 10
) (
  input  pc_sel_t      sel,
  input  logic [D-1:0] pc,
  input  logic [D-1:0] target,
  input  logic [D-1:0] link,
  output logic [D-1:0] pc_nxt,
  output logic [D-1:0] pc_inc
);

  logic [D-1:0] pc_rel_s;
  logic [D-1:0] one_s;

  assign one_s  = {{(D-1){1'b0}}, 1'b1};
  assign pc_inc = pc + one_s;
  // target is already D bits wide, so a D-bit add is exactly
  // pc + sign-extended target truncated to D bits.
  assign pc_rel_s = pc + target;

  // Next-PC source mux.
  always_comb begin
    pc_nxt = pc;
    case (sel)
      SEL_HOLD: pc_nxt = pc;
      SEL_ZERO: pc_nxt = D'(PC_RESET);
      SEL_INC:  pc_nxt = pc_inc;
      SEL_ABS:  pc_nxt = target;
      SEL_REL:  pc_nxt = pc_rel_s;
      SEL_LINK: pc_nxt = link;
      default:  pc_nxt = pc;
    endcase
  end

endmodule : pc_next

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Purpose : Program counter with IDLE/RUN/HALT control FSM, stall, halt,
//           absolute and relative jumps, and an optional one-entry link
//           register for call/ret.
// Config  : define PC_LINK_EN to compile in the link register; without it
//           call and ret are ignored and no link storage exists.
// Ports   :
//   clk       in  1 : clock, all state updates on the rising edge
//   reset_n   in  1 : synchronous active-low reset, overrides everything
//   start     in  1 : start execution from address 0 (IDLE or HALT)
//   stall     in  1 : freeze pc and state while running
//   halt      in  1 : current instruction is a halt
//   abs_jump  in  1 : load target as absolute address
//   rel_jump  in  1 : add target to pc as signed offset
//   target    in  D : jump address / offset
//   call      in  1 : call (link <= pc+1, pc <= target) when PC_LINK_EN
//   ret       in  1 : return (pc <= link) when PC_LINK_EN
//   pc        out D : address being fetched (registered)
//   running   out 1 : high in RUN (registered)
//   done      out 1 : high in HALT (registered)
// -----------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         abs_jump,
  input  logic         rel_jump,
  input  logic [D-1:0] target,
  input  logic         call,
  input  logic         ret,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done
);

  pc_state_t    state_r;
  pc_state_t    state_s;
  pc_sel_t      sel_s;
  logic [D-1:0] pc_r;
  logic [D-1:0] pc_nxt_s;
  logic [D-1:0] pc_inc_s;
  logic [D-1:0] link_s;
  logic         running_r;
  logic         running_s;
  logic         done_r;
  logic         done_s;

`ifdef PC_LINK_EN
  logic [D-1:0] link_r;
  logic         link_we_s;
  assign link_s = link_r;
`else
  // No link storage: the return path reads zero and is never selected.
  logic unused_s;
  assign link_s   = {D{1'b0}};
  assign unused_s = call ^ ret ^ (^pc_inc_s);
`endif

  // Next-state, next-PC source and registered-output decode.
  always_comb begin
    state_s = state_r;
    sel_s   = SEL_HOLD;
`ifdef PC_LINK_EN
    link_we_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          sel_s   = SEL_ZERO;
        end else begin
          state_s = ST_IDLE;
          sel_s   = SEL_HOLD;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at while running.
        if (stall) begin
          state_s = ST_RUN;
          sel_s   = SEL_HOLD;
        end else if (halt) begin
          state_s = ST_HALT;
          sel_s   = SEL_HOLD;
`ifdef PC_LINK_EN
        end else if (ret) begin
          state_s = ST_RUN;
          sel_s   = SEL_LINK;
        end else if (call) begin
          state_s   = ST_RUN;
          sel_s     = SEL_ABS;
          link_we_s = 1'b1;
`endif
        end else if (abs_jump) begin
          state_s = ST_RUN;
          sel_s   = SEL_ABS;
        end else if (rel_jump) begin
          state_s = ST_RUN;
          sel_s   = SEL_REL;
        end else begin
          state_s = ST_RUN;
          sel_s   = SEL_INC;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_s = ST_RUN;
          sel_s   = SEL_ZERO;
        end else begin
          state_s = ST_HALT;
          sel_s   = SEL_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sel_s   = SEL_ZERO;
      end
    endcase
    // Status flags are derived from the next state so they register
    // alongside it and line up with the new state.
    running_s = (state_s == ST_RUN);
    done_s    = (state_s == ST_HALT);
  end

  pc_next #(
    .D (D)
  ) u_pc_next (
    .sel    (sel_s),
    .pc     (pc_r),
    .target (target),
    .link   (link_s),
    .pc_nxt (pc_nxt_s),
    .pc_inc (pc_inc_s)
  );

  // State, PC and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= D'(PC_RESET);
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_nxt_s;
      running_r <= running_s;
      done_r    <= done_s;
    end
  end

`ifdef PC_LINK_EN
  // Link register: captures the return address on a taken call.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      link_r <= {D{1'b0}};
    end else if (link_we_s) begin
      link_r <= pc_inc_s;
    end else begin
      link_r <= link_r;
    end
  end
`endif

  assign pc      = pc_r;
  assign running = running_r;
  assign done    = done_r;

endmodule : program_counter
